// File: rtl/ysyx_25040109_idu_stage.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25040109_idu_stage
// Purpose  : Registered RV32I(+M, +Zicsr) decode stage between IFU and EXU.
//            Fetched {pc, inst} pairs go into a DEPTH-entry circular queue.
//            The queue head is decoded combinationally and captured into a
//            registered bundle that EXU takes over a valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous redirect, empties queue and output reg
//   in_valid/in_ready   : IFU handshake (in_ready = queue not full)
//   in_inst, in_pc      : fetched instruction word and its PC
//   out_valid/out_ready : EXU handshake for the decoded bundle
//   out_pc, out_inst    : PC and raw word of the bundle
//   out_opcode .. out_funct7 : raw instruction fields
//   out_imm             : decoded immediate
//   out_rf_wen, out_is_*: control flags (all zero on an illegal instruction)
//   out_csr_addr        : CSR address for legal CSR ops, else zero
//   out_inst_invalid    : illegal instruction
//   q_count             : queue occupancy (bundle register not included)
// ============================================================================
module ysyx_25040109_idu_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned EN_M     = 1,
  parameter int unsigned EN_ZICSR = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_inst,
  output logic [6:0]               out_opcode,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [2:0]               out_funct3,
  output logic [6:0]               out_funct7,
  output logic [31:0]              out_imm,
  output logic                     out_rf_wen,
  output logic                     out_is_load,
  output logic                     out_is_store,
  output logic                     out_is_branch,
  output logic                     out_is_csr,
  output logic                     out_is_ecall,
  output logic                     out_is_ebreak,
  output logic                     out_is_mret,
  output logic [11:0]              out_csr_addr,
  output logic                     out_inst_invalid,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  // Bit positions inside the registered flag vector.
  localparam int unsigned FL_RF_WEN  = 0;
  localparam int unsigned FL_LOAD    = 1;
  localparam int unsigned FL_STORE   = 2;
  localparam int unsigned FL_BRANCH  = 3;
  localparam int unsigned FL_CSR     = 4;
  localparam int unsigned FL_ECALL   = 5;
  localparam int unsigned FL_EBREAK  = 6;
  localparam int unsigned FL_MRET    = 7;
  localparam int unsigned FL_INVALID = 8;

  // --------------------------------------------------------------------------
  // Queue state
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  // Output bundle registers. Raw fields are sliced out of inst_q.
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] pc_q,    pc_d;
  logic [31:0]     inst_q,  inst_d;
  logic [31:0]     imm_q,   imm_d;
  logic [8:0]      flags_q, flags_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Flush wins over both sides of the queue in the same cycle.
  assign push = in_valid && !full && !flush;
  assign pop  = !empty && (!out_valid_q || out_ready) && !flush;

  // --------------------------------------------------------------------------
  // Head decode
  // --------------------------------------------------------------------------
  logic [31:0]     head_inst;
  logic [XLEN-1:0] head_pc;
  logic [6:0]      h_op;
  logic [2:0]      h_f3;
  logic [6:0]      h_f7;
  logic [11:0]     h_f12;

  assign head_inst = inst_mem[rd_ptr_q];
  assign head_pc   = pc_mem[rd_ptr_q];
  assign h_op      = head_inst[6:0];
  assign h_f3      = head_inst[14:12];
  assign h_f7      = head_inst[31:25];
  assign h_f12     = head_inst[31:20];

  logic       dec_legal;
  logic [7:0] dec_raw;     // flags before masking by legality
  logic [8:0] dec_flags;
  logic [31:0] dec_imm;

  always_comb begin
    dec_legal = 1'b0;
    dec_raw   = '0;
    case (h_op)
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        dec_legal            = 1'b1;
        dec_raw[FL_RF_WEN]   = 1'b1;
      end
      OPC_JALR: begin
        dec_legal            = (h_f3 == 3'b000);
        dec_raw[FL_RF_WEN]   = 1'b1;
      end
      OPC_LOAD: begin
        dec_legal            = h_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        dec_raw[FL_RF_WEN]   = 1'b1;
        dec_raw[FL_LOAD]     = 1'b1;
      end
      OPC_STORE: begin
        dec_legal            = h_f3 inside {3'b000, 3'b001, 3'b010};
        dec_raw[FL_STORE]    = 1'b1;
      end
      OPC_BRANCH: begin
        dec_legal            = !(h_f3 inside {3'b010, 3'b011});
        dec_raw[FL_BRANCH]   = 1'b1;
      end
      OPC_OP_IMM: begin
        // Only the shift encodings constrain funct7 (shamt lives in rs2).
        case (h_f3)
          3'b001:  dec_legal = (h_f7 == F7_BASE);
          3'b101:  dec_legal = (h_f7 == F7_BASE) || (h_f7 == F7_ALT);
          default: dec_legal = 1'b1;
        endcase
        dec_raw[FL_RF_WEN]   = 1'b1;
      end
      OPC_OP: begin
        if (h_f7 == F7_BASE) begin
          dec_legal = 1'b1;
        end else if (h_f7 == F7_ALT) begin
          dec_legal = (h_f3 == 3'b000) || (h_f3 == 3'b101);   // SUB, SRA
        end else if (h_f7 == F7_MUL) begin
          dec_legal = (EN_M != 0);
        end
        dec_raw[FL_RF_WEN]   = 1'b1;
      end
      OPC_SYSTEM: begin
        if (h_f3 == 3'b000) begin
          case (h_f12)
            12'h000: begin dec_legal = 1'b1; dec_raw[FL_ECALL]  = 1'b1; end
            12'h001: begin dec_legal = 1'b1; dec_raw[FL_EBREAK] = 1'b1; end
            12'h302: begin dec_legal = 1'b1; dec_raw[FL_MRET]   = 1'b1; end
            default: dec_legal = 1'b0;
          endcase
        end else if (h_f3 != 3'b100) begin
          dec_legal            = (EN_ZICSR != 0);
          dec_raw[FL_CSR]      = 1'b1;
          dec_raw[FL_RF_WEN]   = 1'b1;
        end
      end
      default: dec_legal = 1'b0;
    endcase
    dec_flags = {!dec_legal, dec_raw & {8{dec_legal}}};
  end

  // The immediate follows the encoding format, independent of legality.
  always_comb begin
    dec_imm = '0;
    case (h_op)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        dec_imm = {{20{head_inst[31]}}, head_inst[31:20]};
      OPC_STORE:
        dec_imm = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
      OPC_BRANCH:
        dec_imm = {{19{head_inst[31]}}, head_inst[31], head_inst[7],
                   head_inst[30:25], head_inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        dec_imm = {head_inst[31:12], 12'b0};
      OPC_JAL:
        dec_imm = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
                   head_inst[20], head_inst[30:21], 1'b0};
      OPC_SYSTEM:
        if (head_inst[14]) dec_imm = {27'b0, head_inst[19:15]};  // zimm forms
      default: dec_imm = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    imm_d       = imm_q;
    flags_d     = flags_q;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      // Pointers are AW bits wide and DEPTH is a power of two, so the
      // increment wraps modulo DEPTH on its own.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      if (pop) begin
        out_valid_d = 1'b1;
        pc_d        = head_pc;
        inst_d      = head_inst;
        imm_d       = dec_imm;
        flags_d     = dec_flags;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;   // drained; fields keep their last value
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // Queue storage carries no reset: an entry is only ever read after it has
  // been written, and the pointers/count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= in_pc;
      inst_mem[wr_ptr_q] <= in_inst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      inst_q      <= '0;
      imm_q       <= '0;
      flags_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      imm_q       <= imm_d;
      flags_q     <= flags_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready         = !full;
  assign q_count          = count_q;
  assign out_valid        = out_valid_q;
  assign out_pc           = pc_q;
  assign out_inst         = inst_q;
  assign out_opcode       = inst_q[6:0];
  assign out_rd           = inst_q[11:7];
  assign out_funct3       = inst_q[14:12];
  assign out_rs1          = inst_q[19:15];
  assign out_rs2          = inst_q[24:20];
  assign out_funct7       = inst_q[31:25];
  assign out_imm          = imm_q;
  assign out_rf_wen       = flags_q[FL_RF_WEN];
  assign out_is_load      = flags_q[FL_LOAD];
  assign out_is_store     = flags_q[FL_STORE];
  assign out_is_branch    = flags_q[FL_BRANCH];
  assign out_is_csr       = flags_q[FL_CSR];
  assign out_is_ecall     = flags_q[FL_ECALL];
  assign out_is_ebreak    = flags_q[FL_EBREAK];
  assign out_is_mret      = flags_q[FL_MRET];
  assign out_inst_invalid = flags_q[FL_INVALID];
  assign out_csr_addr     = flags_q[FL_CSR] ? inst_q[31:20] : 12'd0;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040109_idu_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25040109_idu_stage
// Purpose  : Self-checking bench for the IDU stage. Two instances share one
//            input stream: "a" with M and Zicsr enabled, "b" with both
//            disabled. A queue-based reference model predicts every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25040109_idu_stage;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  localparam int K_NONE = 0, K_LUI = 1, K_AUIPC = 2, K_JAL = 3, K_JALR = 4,
                 K_LOAD = 5, K_STORE = 6, K_BRANCH = 7, K_OPIMM = 8, K_OP = 9,
                 K_ECALL = 10, K_EBREAK = 11, K_MRET = 12, K_CSR = 13, K_MUL = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        out_ready = 1'b0;

  always #5 clk = ~clk;

  // ---------------- instance a ----------------
  logic a_in_ready, a_out_valid, a_rf_wen, a_is_load, a_is_store, a_is_branch;
  logic a_is_csr, a_is_ecall, a_is_ebreak, a_is_mret, a_invalid;
  logic [31:0] a_out_pc, a_out_inst, a_imm;
  logic [6:0]  a_opcode, a_f7;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [2:0]  a_f3;
  logic [11:0] a_csr_addr;
  logic [CW-1:0] a_q_count;
  logic [127:0] a_bundle;

  ysyx_25040109_idu_stage #(.XLEN(32), .DEPTH(DEPTH), .EN_M(1), .EN_ZICSR(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc), .out_inst(a_out_inst),
    .out_opcode(a_opcode), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_funct3(a_f3), .out_funct7(a_f7), .out_imm(a_imm), .out_rf_wen(a_rf_wen),
    .out_is_load(a_is_load), .out_is_store(a_is_store), .out_is_branch(a_is_branch),
    .out_is_csr(a_is_csr), .out_is_ecall(a_is_ecall), .out_is_ebreak(a_is_ebreak),
    .out_is_mret(a_is_mret), .out_csr_addr(a_csr_addr), .out_inst_invalid(a_invalid),
    .q_count(a_q_count)
  );

  assign a_bundle = {43'b0, a_opcode, a_rd, a_rs1, a_rs2, a_f3, a_f7, a_imm,
                     a_rf_wen, a_is_load, a_is_store, a_is_branch, a_is_csr,
                     a_is_ecall, a_is_ebreak, a_is_mret, a_csr_addr, a_invalid};

  // ---------------- instance b ----------------
  logic b_in_ready, b_out_valid, b_rf_wen, b_is_load, b_is_store, b_is_branch;
  logic b_is_csr, b_is_ecall, b_is_ebreak, b_is_mret, b_invalid;
  logic [31:0] b_out_pc, b_out_inst, b_imm;
  logic [6:0]  b_opcode, b_f7;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_f3;
  logic [11:0] b_csr_addr;
  logic [CW-1:0] b_q_count;
  logic [127:0] b_bundle;

  ysyx_25040109_idu_stage #(.XLEN(32), .DEPTH(DEPTH), .EN_M(0), .EN_ZICSR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc), .out_inst(b_out_inst),
    .out_opcode(b_opcode), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_funct3(b_f3), .out_funct7(b_f7), .out_imm(b_imm), .out_rf_wen(b_rf_wen),
    .out_is_load(b_is_load), .out_is_store(b_is_store), .out_is_branch(b_is_branch),
    .out_is_csr(b_is_csr), .out_is_ecall(b_is_ecall), .out_is_ebreak(b_is_ebreak),
    .out_is_mret(b_is_mret), .out_csr_addr(b_csr_addr), .out_inst_invalid(b_invalid),
    .q_count(b_q_count)
  );

  assign b_bundle = {43'b0, b_opcode, b_rd, b_rs1, b_rs2, b_f3, b_f7, b_imm,
                     b_rf_wen, b_is_load, b_is_store, b_is_branch, b_is_csr,
                     b_is_ecall, b_is_ebreak, b_is_mret, b_csr_addr, b_invalid};

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t mq[$];
  ent_t mout;
  bit   mvalid = 0;

  // Two's-complement interpretation of the low 'bits' bits of v.
  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    return v[bits-1] ? (v - (32'd1 << bits)) : v;
  endfunction

  function automatic logic [127:0] ref_decode(input logic [31:0] i, input bit en_m, input bit en_z);
    int kind;
    logic [31:0] imm;
    bit legal;
    kind = K_NONE;
    casez (i)
      32'b???????_?????_?????_???_?????_0110111: kind = K_LUI;
      32'b???????_?????_?????_???_?????_0010111: kind = K_AUIPC;
      32'b???????_?????_?????_???_?????_1101111: kind = K_JAL;
      32'b???????_?????_?????_000_?????_1100111: kind = K_JALR;
      32'b???????_?????_?????_000_?????_0000011,
      32'b???????_?????_?????_001_?????_0000011,
      32'b???????_?????_?????_010_?????_0000011,
      32'b???????_?????_?????_100_?????_0000011,
      32'b???????_?????_?????_101_?????_0000011: kind = K_LOAD;
      32'b???????_?????_?????_000_?????_0100011,
      32'b???????_?????_?????_001_?????_0100011,
      32'b???????_?????_?????_010_?????_0100011: kind = K_STORE;
      32'b???????_?????_?????_00?_?????_1100011,
      32'b???????_?????_?????_1??_?????_1100011: kind = K_BRANCH;
      32'b???????_?????_?????_000_?????_0010011,
      32'b???????_?????_?????_01?_?????_0010011,
      32'b???????_?????_?????_1?0_?????_0010011,
      32'b???????_?????_?????_111_?????_0010011,
      32'b0000000_?????_?????_001_?????_0010011,
      32'b0000000_?????_?????_101_?????_0010011,
      32'b0100000_?????_?????_101_?????_0010011: kind = K_OPIMM;
      32'b0000000_?????_?????_???_?????_0110011,
      32'b0100000_?????_?????_000_?????_0110011,
      32'b0100000_?????_?????_101_?????_0110011: kind = K_OP;
      32'b0000001_?????_?????_???_?????_0110011: kind = en_m ? K_MUL : K_NONE;
      32'b0000000_00000_?????_000_?????_1110011: kind = K_ECALL;
      32'b0000000_00001_?????_000_?????_1110011: kind = K_EBREAK;
      32'b0011000_00010_?????_000_?????_1110011: kind = K_MRET;
      32'b???????_?????_?????_001_?????_1110011,
      32'b???????_?????_?????_01?_?????_1110011,
      32'b???????_?????_?????_101_?????_1110011,
      32'b???????_?????_?????_11?_?????_1110011: kind = en_z ? K_CSR : K_NONE;
      default: kind = K_NONE;
    endcase
    legal = (kind != K_NONE);

    imm = 32'd0;
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: imm = sext(32'(i[31:20]), 12);
      7'b0100011: imm = sext(32'({i[31:25], i[11:7]}), 12);
      7'b1100011: imm = sext(32'({i[31], i[7], i[30:25], i[11:8]}) * 2, 13);
      7'b1101111: imm = sext(32'({i[31], i[19:12], i[20], i[30:21]}) * 2, 21);
      7'b0110111, 7'b0010111: imm = i & 32'hFFFF_F000;
      7'b1110011: if (i[14]) imm = 32'(i[19:15]);
      default: imm = 32'd0;
    endcase

    return {43'b0, i[6:0], i[11:7], i[19:15], i[24:20], i[14:12], i[31:25], imm,
            (kind inside {K_LUI, K_AUIPC, K_JAL, K_JALR, K_LOAD, K_OPIMM, K_OP, K_MUL, K_CSR}),
            (kind == K_LOAD), (kind == K_STORE), (kind == K_BRANCH), (kind == K_CSR),
            (kind == K_ECALL), (kind == K_EBREAK), (kind == K_MRET),
            (kind == K_CSR) ? i[31:20] : 12'd0, !legal};
  endfunction

  task automatic model_edge(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                            input bit rdy, input bit fl);
    bit can_push;
    bit can_pop;
    can_push = v && (mq.size() < DEPTH);
    can_pop  = (mq.size() > 0) && (!mvalid || rdy);
    if (fl) begin
      mq.delete();
      mvalid = 0;
    end else begin
      if (can_pop) begin
        mout   = mq.pop_front();
        mvalid = 1;
      end else if (mvalid && rdy) begin
        mvalid = 0;
      end
      if (can_push) mq.push_back('{pc, inst});
    end
  endtask

  task automatic compare_all();
    check("a_in_ready",  a_in_ready,  mq.size() < DEPTH);
    check("b_in_ready",  b_in_ready,  mq.size() < DEPTH);
    check("a_q_count",   a_q_count,   mq.size());
    check("b_q_count",   b_q_count,   mq.size());
    check("a_out_valid", a_out_valid, mvalid);
    check("b_out_valid", b_out_valid, mvalid);
    if (mvalid) begin
      check("a_out_pc",   a_out_pc,   mout.pc);
      check("b_out_pc",   b_out_pc,   mout.pc);
      check("a_out_inst", a_out_inst, mout.inst);
      check("b_out_inst", b_out_inst, mout.inst);
      check("a_bundle",   a_bundle,   ref_decode(mout.inst, 1, 1));
      check("b_bundle",   b_bundle,   ref_decode(mout.inst, 0, 0));
    end
  endtask

  // One clock: drive at posedge+1, compare at negedge, advance model, edge.
  task automatic cycle(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                       input bit rdy, input bit fl);
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = rdy; flush = fl;
    @(negedge clk);
    compare_all();
    model_edge(v, inst, pc, rdy, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; flush = 0;
    rst_n = 0;
    mq.delete();
    mvalid = 0;
    #1;
    check("rst_a_q_count",   a_q_count,   0);
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_in_ready",  a_in_ready,  1);
    check("rst_a_bundle",    a_bundle,    0);
    check("rst_a_out_pc",    a_out_pc,    0);
    check("rst_b_bundle",    b_bundle,    0);
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0] ops [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
                             7'b0100011, 7'b1100011, 7'b0010011, 7'b0110011, 7'b1110011};
    logic [11:0] sysf [3] = '{12'h000, 12'h001, 12'h302};
    int k;
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 10) w[6:0] = ops[k];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'b0000000;
      1: w[31:25] = 7'b0100000;
      2: w[31:25] = 7'b0000001;
      default: ;
    endcase
    if (w[6:0] == 7'b1110011 && $urandom_range(0, 1) == 1) begin
      w[14:12] = 3'b000;
      w[31:20] = sysf[$urandom_range(0, 2)];
    end
    return w;
  endfunction

  logic [31:0] pc_ctr = 32'h8000_0000;

  initial begin
    // Reset state.
    @(negedge clk);
    check("reset_bundle_a", a_bundle, 0);
    check("reset_bundle_b", b_bundle, 0);
    compare_all();
    @(posedge clk); #1;
    rst_n = 1;

    // ADDI x1, x0, 5 : valid after two edges.
    cycle(1, 32'h0050_0093, 32'h8000_0000, 1, 0);
    cycle(0, 32'h0, 32'h0, 1, 0);
    check("addi_valid",  a_out_valid, 1);
    check("addi_rd",     a_rd,        1);
    check("addi_imm",    a_imm,       5);
    check("addi_rf_wen", a_rf_wen,    1);
    check("addi_pc",     a_out_pc,    32'h8000_0000);
    cycle(0, 32'h0, 32'h0, 1, 0);

    // MUL, CSRRW mtvec, CSRRWI.
    cycle(1, 32'h0220_8033, 32'h8000_0004, 1, 0);
    cycle(1, 32'h3052_9073, 32'h8000_0008, 1, 0);
    cycle(1, 32'h3052_d073, 32'h8000_000c, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 32'h0, 32'h0, 1, 0);

    // Back-pressure: fill past the queue, then drain.
    for (int i = 0; i < 6; i++) cycle(1, 32'h0000_0013 | (i << 20), 32'h1000 + i * 4, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 32'h0, 32'h0, 1, 0);

    // Fill then flush together with a push; the pushed word must vanish.
    for (int i = 0; i < 4; i++) cycle(1, 32'h0010_0093 + (i << 7), 32'h2000 + i * 4, 0, 0);
    cycle(1, 32'hDEAD_00B7, 32'h2FFC, 0, 1);
    check("flush_q_count",   a_q_count,   0);
    check("flush_out_valid", a_out_valid, 0);
    for (int i = 0; i < 4; i++) cycle(0, 32'h0, 32'h0, 1, 0);

    // Stream 8 with out_ready toggling; pointers wrap.
    for (int i = 0; i < 8; i++) cycle(1, 32'h0000_0113 | (i << 20), 32'h3000 + i * 4, (i % 2) == 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 32'h0, 32'h0, 1, 0);

    // Randomized traffic with a mid-run reset.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      cycle($urandom_range(0, 3) != 0, rand_inst(), pc_ctr,
            $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
      pc_ctr += 4;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
